mem_tg2_csr_seq: RTL
====================

Name: mem_tg2_csr_seq

Overview:
AVMM initiator that drives the memory traffic-generator CSR block from the host side, so a test needs no software. On a command it writes TG_CTRL to start one TG, then polls TG_STAT until that TG finishes. It then reads the TG's 64-bit clock count and reports a result code. It sits between a BIST/debug controller and the CSR sink port of the TG CSR block.

Parameters:
NUM_TG, 4, number of traffic generators behind the CSR block
CTRL_ADDR, 'h30, byte address of TG_CTRL
STAT_ADDR, 'h38, byte address of first TG_STAT register
CLOCKS_ADDR, 'h50, byte address of TG0 clock count; TGn is at CLOCKS_ADDR+8*n
POLL_GAP, 16, idle cycles between status polls
MAX_POLLS, 65535, number of polls before the result is POLL_EXPIRE
RSP_TIMEOUT, 1024, maximum cycles to wait for a response or for waitrequest to drop

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_start  in  1  one-cycle request to start a run; sampled only in IDLE
cmd_tg_sel  in  $clog2(NUM_TG)  TG index to run
busy  out  1  high from command accept until done
done  out  1  one-cycle pulse when result is valid
result  out  3  0 PASS, 1 FAIL, 2 TIMEOUT, 3 POLL_EXPIRE, 4 BUS_ERR, 5 BAD_SEL
clk_count  out  64  clock count read back; valid with done
avmm_address  out  21  byte address
avmm_read  out  1  read command
avmm_write  out  1  write command
avmm_writedata  out  64  write data
avmm_byteenable  out  8  always 'hff
avmm_waitrequest  in  1  responder stall
avmm_readdata  in  64  read data
avmm_readdatavalid  in  1  read data strobe
avmm_writeresponsevalid  in  1  write completion strobe

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
- Reset values: all outputs 0, FSM in IDLE, all counters 0. An rst_n assertion in any state aborts the run: no done pulse and no further bus commands.
- IDLE, cmd_start=1, cmd_tg_sel<NUM_TG: latch sel, set busy next cycle, go to WR_CTRL.
- IDLE, cmd_start=1, cmd_tg_sel>=NUM_TG: go to DONE with result BAD_SEL and no bus activity.
- cmd_start is ignored while busy.
- Command hold rule: address, data and read/write stay stable while avmm_waitrequest=1. The command is accepted on the first cycle avmm_waitrequest=0 and deasserted the next cycle. Only one command is outstanding at a time.
- WR_CTRL: write writedata=1<<sel to CTRL_ADDR. On accept go to WR_RSP.
- WR_RSP: wait for avmm_writeresponsevalid, then go to POLL_RD.
- POLL_RD: read STAT_ADDR+8*(sel/16). On accept go to POLL_WAIT.
- POLL_WAIT: on avmm_readdatavalid take the status nibble s = readdata[4*(sel%16)+:4], where s[3]=active, s[2]=timeout, s[1]=fail, s[0]=pass.
  - Run is complete when active=0 and any of pass/fail/timeout is set.
  - Result priority when several bits are set: timeout > fail > pass.
  - Complete: go to CLK_RD.
  - Not complete: increment the poll counter. If the count equals MAX_POLLS, go to DONE with POLL_EXPIRE and skip the clock read. Otherwise go to GAP.
- GAP: count POLL_GAP cycles, then go to POLL_RD. With POLL_GAP=0 the next read issues the cycle after readdatavalid.
- CLK_RD / CLK_WAIT: read CLOCKS_ADDR+8*sel and latch avmm_readdata into clk_count.
- DONE: drive done=1 for one cycle and clear busy on the same edge. result and clk_count hold until the next accepted command; clk_count=0 for every result except PASS/FAIL/TIMEOUT.
- Bus watchdog: a counter restarts on each command assertion. If RSP_TIMEOUT cycles pass in any waitrequest or response wait, go to DONE with BUS_ERR. Late responses after a BUS_ERR are ignored.
- Unexpected strobes: readdatavalid or writeresponsevalid outside a wait state are ignored.
- Width rules: the poll counter is 16 bits and saturates at MAX_POLLS. Addresses are computed without wrap in 21 bits.

Decomposition:
- tg2_csr_pkg gets the stat-nibble typedef (active, timeout, fail, pass) and the result enum t_tg_seq_result.
- Default register offsets are derived from the existing TG CSR index constants times 8.
- Single module. One generic sub-module, mem_tg_seq_timer (load/count/expire), is instantiated twice: once for the gap and once for the watchdog.

Test Plan:
- sel=2, responder returns nibble 'h8 twice then 'h1, clock reg 'd5000 -> CTRL write data 'h4, 3 stat reads, done with result=0 and clk_count=5000.
- Stat nibble 'h6 (timeout and fail, active=0) -> result=2 (TIMEOUT), clock read still performed.
- Responder holds waitrequest=1 for 10 cycles on the CTRL write -> address/data stable for all 10 cycles, write drops the cycle after accept.
- MAX_POLLS=3, responder always returns active -> exactly 3 stat reads, result=3, no clock read, clk_count=0.
- readdatavalid never returned, RSP_TIMEOUT=32 -> done exactly 32 cycles after the read is accepted, result=4.
- rst_n asserted in POLL_WAIT -> outputs 0 asynchronously. cmd_tg_sel=NUM_TG after reset -> done with result=5 and zero bus commands.

Source files
------------

// File: rtl/tg2_csr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tg2_csr_pkg
// Description : Shared types and register offsets for the TG CSR sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package tg2_csr_pkg;

  // TG CSR block register indices (64-bit registers, 8-byte stride)
  localparam int TG_CTRL_IDX   = 6;
  localparam int TG_STAT_IDX   = 7;
  localparam int TG_CLOCKS_IDX = 10;
  localparam int CSR_ADDR_W    = 21;

  // One TG's status nibble as it appears in TG_STAT
  typedef struct packed {
    logic active;
    logic timeout;
    logic fail;
    logic pass;
  } t_stat_nibble;

  typedef enum logic [2:0] {
    RES_PASS        = 3'd0,
    RES_FAIL        = 3'd1,
    RES_TIMEOUT     = 3'd2,
    RES_POLL_EXPIRE = 3'd3,
    RES_BUS_ERR     = 3'd4,
    RES_BAD_SEL     = 3'd5
  } t_tg_seq_result;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_CTRL   = 4'd1,
    S_WR_RSP    = 4'd2,
    S_POLL_RD   = 4'd3,
    S_POLL_WAIT = 4'd4,
    S_GAP       = 4'd5,
    S_CLK_RD    = 4'd6,
    S_CLK_WAIT  = 4'd7,
    S_DONE      = 4'd8
  } t_seq_state;

  // A run is finished once the TG is idle and reports some verdict
  function automatic logic stat_complete(input t_stat_nibble s);
    return !s.active && (s.timeout || s.fail || s.pass);
  endfunction

  // Verdict priority: timeout beats fail beats pass
  function automatic t_tg_seq_result stat_result(input t_stat_nibble s);
    if (s.timeout)   return RES_TIMEOUT;
    else if (s.fail) return RES_FAIL;
    else             return RES_PASS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_tg_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_tg_seq_timer
// Description : Loadable down-counter; expired is high while the count is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tg_seq_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);

  logic [WIDTH-1:0] cnt_q;

  // Load has priority; counting stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   cnt_q <= '0;
    else if (load)                cnt_q <= load_val;
    else if (en && cnt_q != '0)   cnt_q <= cnt_q - WIDTH'(1);
  end

  assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_tg2_csr_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_tg2_csr_seq
// Description : AVMM initiator that starts one TG through TG_CTRL, polls
//               TG_STAT until it finishes, reads its clock count and reports
//               a result code.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_tg2_csr_seq
  import tg2_csr_pkg::*;
#(
  parameter int NUM_TG      = 4,
  parameter int CTRL_ADDR   = TG_CTRL_IDX * 8,
  parameter int STAT_ADDR   = TG_STAT_IDX * 8,
  parameter int CLOCKS_ADDR = TG_CLOCKS_IDX * 8,
  parameter int POLL_GAP    = 16,
  parameter int MAX_POLLS   = 65535,
  parameter int RSP_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_start,
  input  logic [$clog2(NUM_TG)-1:0] cmd_tg_sel,
  output logic                      busy,
  output logic                      done,
  output logic [2:0]                result,
  output logic [63:0]               clk_count,
  output logic [20:0]               avmm_address,
  output logic                      avmm_read,
  output logic                      avmm_write,
  output logic [63:0]               avmm_writedata,
  output logic [7:0]                avmm_byteenable,
  input  logic                      avmm_waitrequest,
  input  logic [63:0]               avmm_readdata,
  input  logic                      avmm_readdatavalid,
  input  logic                      avmm_writeresponsevalid
);

  localparam int SEL_W    = $clog2(NUM_TG);
  localparam int WD_W     = $clog2(RSP_TIMEOUT + 1);
  localparam int GAP_W    = $clog2(POLL_GAP + 2);
  localparam int GAP_LOAD = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

  t_seq_state     state_q, state_d;
  t_tg_seq_result result_q, res_nxt;
  logic [SEL_W-1:0] sel_q;
  logic [15:0]      poll_cnt_q;
  logic [63:0]      clk_count_q;
  logic             start, set_res, poll_inc, latch_clk;
  logic             wd_load, wd_exp, gap_load, gap_exp;
  logic [5:0]       nib_lsb;
  t_stat_nibble     stat_nib;

  assign nib_lsb  = 6'(4 * (32'(sel_q) % 16));
  assign stat_nib = t_stat_nibble'(avmm_readdata[nib_lsb +: 4]);

  // Watchdog restarts on every state change, so each command assertion and
  // each response wait gets a full RSP_TIMEOUT budget.
  assign wd_load  = (state_d != state_q) ||
                    (state_q == S_IDLE) || (state_q == S_GAP) || (state_q == S_DONE);
  // Gap timer is held loaded until the sequencer sits in GAP
  assign gap_load = (state_q != S_GAP);

  mem_tg_seq_timer #(.WIDTH(WD_W)) u_wd_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wd_load),
    .load_val (WD_W'(RSP_TIMEOUT - 1)),
    .en       (1'b1),
    .expired  (wd_exp)
  );

  mem_tg_seq_timer #(.WIDTH(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_LOAD)),
    .en       (1'b1),
    .expired  (gap_exp)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, bus command and datapath control decode
  always_comb begin
    state_d         = state_q;
    start           = 1'b0;
    set_res         = 1'b0;
    res_nxt         = RES_PASS;
    poll_inc        = 1'b0;
    latch_clk       = 1'b0;
    avmm_read       = 1'b0;
    avmm_write      = 1'b0;
    avmm_address    = '0;
    avmm_writedata  = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          start = 1'b1;
          if (32'(cmd_tg_sel) >= NUM_TG) begin
            state_d = S_DONE;
            set_res = 1'b1;
            res_nxt = RES_BAD_SEL;
          end else begin
            state_d = S_WR_CTRL;
          end
        end
      end
      S_WR_CTRL: begin
        avmm_write     = 1'b1;
        avmm_address   = 21'(CTRL_ADDR);
        avmm_writedata = 64'(1) << sel_q;
        if (!avmm_waitrequest) state_d = S_WR_RSP;
        else if (wd_exp) begin state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR; end
      end
      S_WR_RSP: begin
        if (avmm_writeresponsevalid) state_d = S_POLL_RD;
        else if (wd_exp) begin state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR; end
      end
      S_POLL_RD: begin
        avmm_read    = 1'b1;
        avmm_address = 21'(STAT_ADDR + 8 * (32'(sel_q) / 16));
        if (!avmm_waitrequest) state_d = S_POLL_WAIT;
        else if (wd_exp) begin state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR; end
      end
      S_POLL_WAIT: begin
        if (avmm_readdatavalid) begin
          if (stat_complete(stat_nib)) begin
            set_res = 1'b1;
            res_nxt = stat_result(stat_nib);
            state_d = S_CLK_RD;
          end else begin
            poll_inc = 1'b1;
            if (({1'b0, poll_cnt_q} + 17'd1) == 17'(MAX_POLLS)) begin
              state_d = S_DONE;
              set_res = 1'b1;
              res_nxt = RES_POLL_EXPIRE;
            end else if (POLL_GAP == 0) begin
              state_d = S_POLL_RD;
            end else begin
              state_d = S_GAP;
            end
          end
        end else if (wd_exp) begin
          state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR;
        end
      end
      S_GAP: begin
        if (gap_exp) state_d = S_POLL_RD;
      end
      S_CLK_RD: begin
        avmm_read    = 1'b1;
        avmm_address = 21'(CLOCKS_ADDR + 8 * 32'(sel_q));
        if (!avmm_waitrequest) state_d = S_CLK_WAIT;
        else if (wd_exp) begin state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR; end
      end
      S_CLK_WAIT: begin
        if (avmm_readdatavalid) begin
          latch_clk = 1'b1;
          state_d   = S_DONE;
        end else if (wd_exp) begin
          state_d = S_DONE; set_res = 1'b1; res_nxt = RES_BUS_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Run context: selected TG, poll count, verdict and clock count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      poll_cnt_q  <= '0;
      clk_count_q <= '0;
      result_q    <= RES_PASS;
    end else begin
      if (start) begin
        sel_q       <= cmd_tg_sel;
        poll_cnt_q  <= '0;
        clk_count_q <= '0;
      end
      if (poll_inc && poll_cnt_q != 16'(MAX_POLLS)) poll_cnt_q <= poll_cnt_q + 16'd1;
      if (latch_clk) clk_count_q <= avmm_readdata;
      if (set_res)   result_q    <= res_nxt;
    end
  end

  // Byte enables only matter with a command, so they follow it and read 0 in reset
  assign avmm_byteenable = (avmm_read || avmm_write) ? 8'hff : 8'h00;
  assign busy            = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done            = (state_q == S_DONE);
  assign result          = result_q;
  assign clk_count       = clk_count_q;

endmodule
`default_nettype wire
